// File: rtl/k16_io_panel.sv
// k16_io_panel: front-panel scanner (LED/switch lanes), debounced switches,
// host register file, free-running timer and a simple tone generator.
module k16_io_panel #(
    parameter int unsigned CLK_HZ   = 25000000,
    parameter int unsigned SCAN_HZ  = 50,
    parameter int unsigned NIB      = 4,
    parameter int unsigned WORDS    = 2,
    parameter int unsigned DEBOUNCE = 3,
    localparam int unsigned STEPS   = WORDS * 16 / NIB,
    localparam int unsigned SW      = (STEPS > 1) ? $clog2(STEPS) : 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [3:0]      addr,
    input  logic [15:0]     din,
    input  logic            write_en,
    output logic [15:0]     dout,
    output logic            stop,
    output logic            cpu_reset,
    output logic [NIB-1:0]  io_leds,
    output logic            io_clk,
    output logic [SW-1:0]   io_addr,
    input  logic [NIB-1:0]  io_switches,
    input  logic [2:0]      io_reg_switches,
    output logic            sound
);

    localparam int unsigned DIV  = CLK_HZ / SCAN_HZ;
    localparam int unsigned HALF = DIV / 2;
    localparam int unsigned PW   = $clog2(DIV);
    localparam int unsigned FW   = WORDS * 16;
    localparam int unsigned SELW = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam int unsigned CW   = (DEBOUNCE > 0) ? $clog2(DEBOUNCE + 1) : 1;

    localparam logic [3:0] A_STATUS   = 4'h0;
    localparam logic [3:0] A_CTRL     = 4'h1;
    localparam logic [3:0] A_SEL      = 4'h2;
    localparam logic [3:0] A_SW_DATA  = 4'h3;
    localparam logic [3:0] A_LED_DATA = 4'h4;
    localparam logic [3:0] A_REG_SW   = 4'h5;
    localparam logic [3:0] A_TIMER_HI = 4'h6;
    localparam logic [3:0] A_TIMER_LO = 4'h7;
    localparam logic [3:0] A_TONE_DIV = 4'h8;
    localparam logic [3:0] A_TONE_LEN = 4'h9;
    localparam logic [3:0] A_ID       = 4'hA;

    logic [PW-1:0]   presc;
    logic [PW-1:0]   presc_nxt_c;
    logic            tick_c;
    logic [SW-1:0]   addr_nxt_c;
    logic            frame_end_c;
    logic [FW-1:0]   raw, prev, deb, led;
    logic [FW-1:0]   raw_new_c, deb_nxt_c;
    logic [CW-1:0]   cnt, cnt_nxt_c;
    logic [2:0]      reg_sw;
    logic [SELW-1:0] sel;
    logic [31:0]     timer;
    logic [15:0]     snapshot;
    logic            frame_done, sw_changed;
    logic [15:0]     tone_div, tone_cnt, tone_phase;
    logic [15:0]     rdata_c;
    logic            rd_status_c, timer_clr_c, wr_len_c;

    assign tick_c      = (presc == PW'(DIV - 1));
    assign presc_nxt_c = tick_c ? '0 : presc + PW'(1);
    assign addr_nxt_c  = (io_addr == SW'(STEPS - 1)) ? '0 : io_addr + SW'(1);
    assign frame_end_c = tick_c && (io_addr == SW'(STEPS - 1));
    assign rd_status_c = (addr == A_STATUS);
    assign timer_clr_c = write_en && (addr == A_CTRL) && din[0];
    assign wr_len_c    = write_en && (addr == A_TONE_LEN);

    assign stop      = deb[(WORDS - 1) * 16];
    assign cpu_reset = deb[(WORDS - 1) * 16 + 1];

    // Prescaler: scan tick at the last count, panel strobe high for the first half
    always_ff @(posedge clk) begin
        if (reset) begin
            presc  <= '0;
            io_clk <= 1'b0;
        end else begin
            presc  <= presc_nxt_c;
            io_clk <= (presc_nxt_c < PW'(HALF));
        end
    end

    // Raw frame with the current lane replaced by the live switch value
    always_comb begin
        raw_new_c = raw;
        raw_new_c[int'(io_addr) * NIB +: NIB] = io_switches;
    end

    // Frame-to-frame match counter and debounced frame candidate
    always_comb begin
        cnt_nxt_c = '0;
        if (raw_new_c == prev) begin
            cnt_nxt_c = (cnt == CW'(DEBOUNCE)) ? cnt : cnt + CW'(1);
        end
        deb_nxt_c = (cnt_nxt_c == CW'(DEBOUNCE)) ? raw_new_c : deb;
    end

    // Lane scan, switch capture and frame-end debounce
    always_ff @(posedge clk) begin
        if (reset) begin
            io_addr <= '0;
            io_leds <= '0;
            raw     <= '0;
            prev    <= '0;
            deb     <= '0;
            cnt     <= '0;
            reg_sw  <= '0;
        end else if (tick_c) begin
            raw     <= raw_new_c;
            io_addr <= addr_nxt_c;
            io_leds <= led[int'(addr_nxt_c) * NIB +: NIB];
            reg_sw  <= io_reg_switches;
            if (frame_end_c) begin
                prev <= raw_new_c;
                cnt  <= cnt_nxt_c;
                deb  <= deb_nxt_c;
            end
        end
    end

    // Host-writable word select and LED words
    always_ff @(posedge clk) begin
        if (reset) begin
            sel      <= '0;
            led      <= '0;
            tone_div <= '0;
        end else if (write_en) begin
            case (addr)
                A_SEL:      sel <= SELW'(din % 16'(WORDS));
                A_LED_DATA: led[int'(sel) * 16 +: 16] <= din;
                A_TONE_DIV: tone_div <= din;
                default:    ;
            endcase
        end
    end

    // Free-running timer; the low half is snapshotted whenever the high half is read
    always_ff @(posedge clk) begin
        if (reset) begin
            timer    <= '0;
            snapshot <= '0;
        end else begin
            timer <= timer_clr_c ? 32'd0 : timer + 32'd1;
            if (addr == A_TIMER_HI) begin
                snapshot <= timer[15:0];
            end
        end
    end

    // Sticky status flags, cleared by a STATUS read; a new event wins over the clear
    always_ff @(posedge clk) begin
        if (reset) begin
            frame_done <= 1'b0;
            sw_changed <= 1'b0;
        end else begin
            frame_done <= frame_end_c || (frame_done && !rd_status_c);
            sw_changed <= (frame_end_c && (deb_nxt_c != deb)) || (sw_changed && !rd_status_c);
        end
    end

    // Tone: toggle every tone_div+1 clocks while the remaining count is nonzero
    always_ff @(posedge clk) begin
        if (reset) begin
            tone_cnt   <= '0;
            tone_phase <= '0;
            sound      <= 1'b0;
        end else if (wr_len_c) begin
            tone_cnt   <= din;
            tone_phase <= '0;
            if (din == 16'd0) begin
                sound <= 1'b0;
            end
        end else if (tone_cnt == 16'd0) begin
            tone_phase <= '0;
            sound      <= 1'b0;
        end else if (tone_phase >= tone_div) begin
            tone_phase <= '0;
            tone_cnt   <= tone_cnt - 16'd1;
            sound      <= (tone_cnt == 16'd1) ? 1'b0 : !sound;
        end else begin
            tone_phase <= tone_phase + 16'd1;
        end
    end

    // Read mux
    always_comb begin
        rdata_c = '0;
        case (addr)
            A_STATUS:   rdata_c = {13'd0, sw_changed, (tone_cnt != 16'd0), frame_done};
            A_SEL:      rdata_c = 16'(sel);
            A_SW_DATA:  rdata_c = deb[int'(sel) * 16 +: 16];
            A_LED_DATA: rdata_c = led[int'(sel) * 16 +: 16];
            A_REG_SW:   rdata_c = {13'd0, reg_sw};
            A_TIMER_HI: rdata_c = timer[31:16];
            A_TIMER_LO: rdata_c = snapshot;
            A_TONE_DIV: rdata_c = tone_div;
            A_TONE_LEN: rdata_c = tone_cnt;
            A_ID:       rdata_c = 16'hEAEA;
            default:    rdata_c = '0;
        endcase
    end

    // Registered read data
    always_ff @(posedge clk) begin
        if (reset) begin
            dout <= '0;
        end else begin
            dout <= rdata_c;
        end
    end

endmodule

// File: tb/tb_k16_io_panel.sv
// Directed bench for k16_io_panel with DIV=10, NIB=4, WORDS=2, DEBOUNCE=3.
module tb_k16_io_panel;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  addr;
    logic [15:0] din;
    logic        write_en;
    logic [15:0] dout;
    logic        stop, cpu_reset;
    logic [3:0]  io_leds;
    logic        io_clk;
    logic [2:0]  io_addr;
    logic [3:0]  io_switches;
    logic [2:0]  io_reg_switches;
    logic        sound;

    int checks   = 0;
    int failures = 0;

    logic [31:0] m_timer = 32'd0;

    k16_io_panel #(
        .CLK_HZ(20), .SCAN_HZ(2), .NIB(4), .WORDS(2), .DEBOUNCE(3)
    ) dut (
        .clk(clk), .reset(reset), .addr(addr), .din(din), .write_en(write_en),
        .dout(dout), .stop(stop), .cpu_reset(cpu_reset), .io_leds(io_leds),
        .io_clk(io_clk), .io_addr(io_addr), .io_switches(io_switches),
        .io_reg_switches(io_reg_switches), .sound(sound)
    );

    always #5 clk = ~clk;

    // Reference timer: counts every clock, zeroed by reset or a CTRL bit0 write
    always @(posedge clk) begin
        if (reset) m_timer <= 32'd0;
        else if (write_en && addr == 4'h1 && din[0]) m_timer <= 32'd0;
        else m_timer <= m_timer + 32'd1;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog sim time exhausted");
        $fatal(1);
    end

    typedef struct packed {
        logic [3:0]  a;
        logic [15:0] d;
        logic        we;
        logic [15:0] exp;
    } vec_t;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [3:0] a, input logic [15:0] d);
        addr = a; din = d; write_en = 1'b1;
        step();
        write_en = 1'b0;
    endtask

    task automatic rd(input logic [3:0] a);
        addr = a; write_en = 1'b0;
        step();
    endtask

    task automatic wait_addr(input logic [2:0] v, input string nm, output int n);
        n = 0;
        while (io_addr !== v && n < 200) begin
            step();
            n++;
        end
        check(nm, 32'(io_addr), 32'(v));
    endtask

    function automatic logic [3:0] lane_of(input logic [31:0] w, input int k);
        return w[k*4 +: 4];
    endfunction

    vec_t        vecs [22];
    logic [31:0] led_img;
    logic [0:9]  snd_exp, busy_exp;
    logic [31:0] snap;
    int          n, ones, guard;

    initial begin
        vecs[0]  = '{4'hA, 16'h0000, 1'b0, 16'hEAEA};
        vecs[1]  = '{4'h2, 16'h0005, 1'b1, 16'h0000};
        vecs[2]  = '{4'h2, 16'h0000, 1'b0, 16'h0001};
        vecs[3]  = '{4'h4, 16'hBEEF, 1'b1, 16'h0000};
        vecs[4]  = '{4'h4, 16'h0000, 1'b0, 16'hBEEF};
        vecs[5]  = '{4'h2, 16'h0000, 1'b1, 16'h0001};
        vecs[6]  = '{4'h4, 16'h0000, 1'b0, 16'h0000};
        vecs[7]  = '{4'h4, 16'h4321, 1'b1, 16'h0000};
        vecs[8]  = '{4'h4, 16'h0000, 1'b0, 16'h4321};
        vecs[9]  = '{4'h3, 16'h0000, 1'b0, 16'h0000};
        vecs[10] = '{4'h8, 16'h0007, 1'b1, 16'h0000};
        vecs[11] = '{4'h8, 16'h0000, 1'b0, 16'h0007};
        vecs[12] = '{4'h9, 16'h0000, 1'b0, 16'h0000};
        vecs[13] = '{4'hB, 16'h1234, 1'b1, 16'h0000};
        vecs[14] = '{4'hB, 16'h0000, 1'b0, 16'h0000};
        vecs[15] = '{4'hF, 16'h0000, 1'b0, 16'h0000};
        vecs[16] = '{4'h5, 16'h0000, 1'b0, 16'h0000};
        vecs[17] = '{4'h1, 16'h0000, 1'b0, 16'h0000};
        vecs[18] = '{4'h2, 16'h0003, 1'b1, 16'h0000};
        vecs[19] = '{4'h2, 16'h0000, 1'b0, 16'h0001};
        vecs[20] = '{4'h2, 16'h0002, 1'b1, 16'h0001};
        vecs[21] = '{4'h2, 16'h0000, 1'b0, 16'h0000};
        led_img  = 32'hBEEF_4321;
        snd_exp  = 10'b0011100000;
        busy_exp = 10'b1111111110;

        reset = 1'b1; addr = 4'h0; din = 16'h0; write_en = 1'b0;
        io_switches = 4'h0; io_reg_switches = 3'd0;
        step(); step(); step();
        check("rst_dout", 32'(dout), 32'h0);
        check("rst_io_addr", 32'(io_addr), 32'h0);
        check("rst_io_leds", 32'(io_leds), 32'h0);
        check("rst_io_clk", 32'(io_clk), 32'h0);
        check("rst_sound", 32'(sound), 32'h0);
        check("rst_stop", 32'(stop), 32'h0);
        reset = 1'b0;

        // Register map vectors: dout shows the pre-write value of the addressed register
        for (int i = 0; i < 22; i++) begin
            addr = vecs[i].a; din = vecs[i].d; write_en = vecs[i].we;
            step();
            check($sformatf("reg_vec%0d", i), 32'(dout), 32'(vecs[i].exp));
        end
        write_en = 1'b0;

        // Scan: lane n of word n/4 appears on io_leds when io_addr becomes n
        io_reg_switches = 3'd5;
        wait_addr(3'd0, "scan_sync", n);
        check("scan_leds0", 32'(io_leds), 32'(lane_of(led_img, 0)));
        for (int k = 1; k <= 8; k++) begin
            wait_addr(3'(k % 8), "scan_addr", n);
            check("scan_gap", 32'(n), 32'd10);
            check("scan_leds", 32'(io_leds), 32'(lane_of(led_img, k % 8)));
        end
        ones = 0;
        for (int j = 0; j < 10; j++) begin
            ones += int'(io_clk);
            step();
        end
        check("io_clk_duty", 32'(ones), 32'd5);
        rd(4'h5);
        check("reg_sw", 32'(dout), 32'd5);

        // Tone: div 2, len 3 -> high for 3 clocks, low 3, then forced low and idle
        wr(4'h8, 16'd2);
        wr(4'h9, 16'd3);
        check("tone_start", 32'(sound), 32'h0);
        addr = 4'h0;
        for (int k = 0; k < 10; k++) begin
            step();
            check($sformatf("tone_snd%0d", k), 32'(sound), 32'(snd_exp[k]));
            check($sformatf("tone_busy%0d", k), 32'(dout[1]), 32'(busy_exp[k]));
        end
        // Tone: div 0 toggles every clock; a length-0 write coinciding with a tick stops it
        wr(4'h8, 16'd0);
        wr(4'h9, 16'd5);
        step(); check("tone0_a", 32'(sound), 32'h1);
        step(); check("tone0_b", 32'(sound), 32'h0);
        step(); check("tone0_c", 32'(sound), 32'h1);
        wr(4'h9, 16'd0);
        check("tone_stop", 32'(sound), 32'h0);
        rd(4'h9);
        check("tone_len0", 32'(dout), 32'h0);
        step();
        check("tone_stay0", 32'(sound), 32'h0);

        // Status: frame_done set by frame end, cleared by read, set wins over clear
        addr = 4'hA;
        wait_addr(3'd7, "st_sync7", n);
        wait_addr(3'd0, "st_sync0", n);
        rd(4'h0); check("st_done1", 32'(dout[0]), 32'h1);
        rd(4'h0); check("st_done0", 32'(dout[0]), 32'h0);
        wait_addr(3'd7, "st_sync7b", n);
        repeat (9) step();
        step(); check("st_coinc_old", 32'(dout[0]), 32'h0);
        step(); check("st_coinc_kept", 32'(dout[0]), 32'h1);
        step(); check("st_coinc_clr", 32'(dout[0]), 32'h0);

        // Debounce: all lanes 3 accepted at the fourth frame end (third match)
        reset = 1'b1; io_switches = 4'h3; addr = 4'hA;
        step(); step(); step();
        reset = 1'b0;
        for (int f = 1; f <= 4; f++) begin
            wait_addr(3'd7, "db_sync7", n);
            wait_addr(3'd0, "db_sync0", n);
            check($sformatf("db_stop_f%0d", f), 32'(stop), 32'(f == 4));
            check($sformatf("db_cpurst_f%0d", f), 32'(cpu_reset), 32'(f == 4));
        end
        wr(4'h2, 16'd1);
        rd(4'h3); check("db_sw1", 32'(dout), 32'h3333);
        rd(4'h0); check("db_changed", 32'(dout[2]), 32'h1);
        rd(4'h0); check("db_changed_clr", 32'(dout[2]), 32'h0);
        addr = 4'hA;
        // One-frame glitch to 0 must not alter the debounced words
        wait_addr(3'd7, "gl_sync7", n);
        wait_addr(3'd0, "gl_sync0", n);
        io_switches = 4'h0;
        wait_addr(3'd7, "gl_sync7b", n);
        wait_addr(3'd0, "gl_sync0b", n);
        io_switches = 4'h3;
        check("gl_stop_g", 32'(stop), 32'h1);
        for (int f = 1; f <= 5; f++) begin
            wait_addr(3'd7, "gl_sync7c", n);
            wait_addr(3'd0, "gl_sync0c", n);
            check($sformatf("gl_stop_f%0d", f), 32'(stop), 32'h1);
        end
        rd(4'h0); check("gl_nochange", 32'(dout[2]), 32'h0);
        rd(4'h3); check("gl_sw1", 32'(dout), 32'h3333);

        // Reset mid-frame and mid-tone
        wr(4'h4, 16'hFFFF);
        wr(4'h8, 16'd0);
        wr(4'h9, 16'd1000);
        addr = 4'hA;
        wait_addr(3'd5, "rs_sync5", n);
        check("rs_pre_leds", 32'(io_leds), 32'hF);
        step(); step(); step();
        check("rs_pre_stop", 32'(stop), 32'h1);
        check("rs_pre_ioclk", 32'(io_clk), 32'h1);
        reset = 1'b1;
        step();
        check("rs_dout", 32'(dout), 32'h0);
        check("rs_stop", 32'(stop), 32'h0);
        check("rs_cpurst", 32'(cpu_reset), 32'h0);
        check("rs_leds", 32'(io_leds), 32'h0);
        check("rs_ioclk", 32'(io_clk), 32'h0);
        check("rs_ioaddr", 32'(io_addr), 32'h0);
        check("rs_sound", 32'(sound), 32'h0);
        step(); step();
        reset = 1'b0;
        for (int j = 1; j <= 9; j++) begin
            step();
            check("rs_notick_addr", 32'(io_addr), 32'h0);
            check("rs_notone", 32'(sound), 32'h0);
        end
        rd(4'hA); check("rs_id", 32'(dout), 32'hEAEA);

        // Timer: pass 0xFFFF, then HI and LO must come from the same count
        guard = 0;
        while (m_timer < 32'h0001_0040 && guard < 70000) begin
            step();
            guard++;
        end
        check("tm_reached", 32'(m_timer >= 32'h0001_0040), 32'h1);
        rd(4'h6);
        snap = m_timer - 32'd1;
        check("tm_hi", 32'(dout), 32'(snap[31:16]));
        rd(4'h7);
        check("tm_lo", 32'(dout), 32'(snap[15:0]));
        wr(4'h1, 16'h0001);
        rd(4'h6);
        check("tm_clr_hi", 32'(dout), 32'h0);
        rd(4'h7);
        check("tm_clr_lo", 32'(dout), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/k16_io_panel.md
K16_IO_PANEL -- requirements
Module: k16_io_panel

Interface
REQ-001 Parameter CLK_HZ, 25000000, system clock frequency.
REQ-002 Parameter SCAN_HZ, 50, scan-step rate; DIV = CLK_HZ/SCAN_HZ (at least 4).
REQ-003 Parameter NIB, 4, scan lane width; legal values are 1, 2, 4, 8 and 16.
REQ-004 Parameter WORDS, 2, number of 16-bit LED words and of 16-bit switch words; STEPS = WORDS*16/NIB; SW = clog2(STEPS).
REQ-005 Parameter DEBOUNCE, 3, number of consecutive identical switch frames required before acceptance.
REQ-006 clk  in  1  system clock; one clock, all logic on its rising edge.
REQ-007 reset  in  1  synchronous, active-high reset.
REQ-008 addr  in  4  register select; din  in  16  write data; write_en  in  1  write strobe.
REQ-009 dout  out  16  registered read data.
REQ-010 stop  out  1  debounced stop switch; cpu_reset  out  1  debounced reset switch.
REQ-011 io_leds  out  NIB  LED lane data; io_clk  out  1  panel strobe; io_addr  out  SW  scan step.
REQ-012 io_switches  in  NIB  switch lane data; io_reg_switches  in  3  register-select switches.
REQ-013 sound  out  1  tone output.

Function
REQ-014 A prescaler shall count 0..DIV-1 and assert a one-cycle tick when the count is DIV-1; io_clk shall be 1 while the count is below DIV/2. No derived clock shall be used.
REQ-015 On tick: capture io_switches into raw-frame lane io_addr; advance io_addr, wrapping from STEPS-1 to 0; load io_leds with LED lane (new io_addr). Lane k maps to word k/(16/NIB), bits [(k%(16/NIB))*NIB +: NIB].
REQ-016 On a tick where io_addr wraps (frame end): if the raw frame equals the previous frame, increment the match count (saturating at DEBOUNCE), else clear it to 0; when the count reaches DEBOUNCE, copy the frame into the debounced switch words.
REQ-017 stop shall equal bit 0 and cpu_reset bit 1 of debounced switch word WORDS-1.
REQ-018 io_reg_switches shall be registered on every tick.
REQ-019 Register map. 0x0 STATUS (R): bit0 frame_done, bit1 tone_busy, bit2 sw_changed. 0x1 CTRL (W): bit0 clears the timer. 0x2 SEL (R/W): word index, with modulo-WORDS applied to writes. 0x3 SW_DATA (R): debounced word [SEL]. 0x4 LED_DATA (R/W): LED word [SEL]. 0x5 REG_SW (R): {13'b0, reg switches}. 0x6 TIMER_HI (R). 0x7 TIMER_LO (R): snapshot. 0x8 TONE_DIV (R/W). 0x9 TONE_LEN (R/W). 0xA ID (R): 16'hEAEA. 0xB-0xF: read 0, writes ignored.
REQ-020 dout shall be updated every cycle from addr with a latency of 1 clock. A read of a R/W register in the same cycle as a write to it shall return the old value.
REQ-021 frame_done shall be set at each frame end. sw_changed shall be set when the debounced words change. Both flags clear when dout is loaded from STATUS. Simultaneous set and clear: set wins.
REQ-022 Timer: 32-bit free-running counter with modulo 2^32 wrap. Reading TIMER_HI shall return bits [31:16] and latch bits [15:0] into the snapshot in the same cycle. A CTRL bit0 write shall zero the counter on the next edge.
REQ-023 Tone: a write to TONE_LEN loads the remaining count. While the count is nonzero, sound shall toggle every TONE_DIV+1 clocks and the count shall decrement on each tick. At count 0, sound shall be 0 and the divider shall be held at 0. tone_busy = (count != 0).
REQ-024 TONE_DIV = 0 shall toggle sound every clock. A TONE_LEN write of 0 shall stop the tone immediately. A TONE_LEN write and a tick in the same cycle: the write wins.

Reset
REQ-025 While reset = 1, the following shall be forced to 0: dout, stop, cpu_reset, io_leds, io_clk, io_addr, sound, prescaler, timer, snapshot, all LED words, raw, previous and debounced frames, match count, SEL, TONE_DIV, TONE_LEN count, and status flags. Reset asserted mid-frame or mid-tone shall abort the frame or tone without a trailing tick.

Verification
REQ-026 Bench parameters shall be CLK_HZ=20, SCAN_HZ=2 (DIV=10), NIB=4, WORDS=2, DEBOUNCE=3.
REQ-027 Scan: write SEL=0 then LED_DATA=16'h4321 -> across ticks io_addr 1,2,3 shows io_leds 2,3,4; io_addr wraps 7->0 after 8 ticks; io_clk is high for 5 of 10 clocks.
REQ-028 Debounce: hold io_switches=4'h3 for all lanes -> SW_DATA[1]=16'h3333 and stop=cpu_reset=1 only after the third matching frame end; a one-frame glitch shall produce no change.
REQ-029 Timer: let the counter pass 16'hFFFF, then read 0x6 then 0x7 -> the HI:LO pair is consistent; a CTRL write of 1 -> the next TIMER_HI read is 0.
REQ-030 Tone: TONE_DIV=2, TONE_LEN=3 -> sound period is 6 clocks, tone_busy drops after 3 ticks, then sound=0.
REQ-031 Status: STATUS read returns bit0=1 after a frame end; the next read returns 0; frame end coinciding with the read -> bit remains 1.
REQ-032 Reset mid-tone and mid-frame -> all outputs 0 on the next edge; ID reads 16'hEAEA afterward.
